// File: rtl/mul_issue_ctrl_pkg.sv
// Shared ALU control codes and MUL sequencer state encoding.
// Imported by ALU_Control, the ALU and the EX-stage multiply sequencer.
package mul_issue_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_XOR  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_MUL  = 4'b0101;
  localparam logic [3:0] ALU_ADDI = 4'b0110;
  localparam logic [3:0] ALU_SRAI = 4'b0111;
  localparam logic [3:0] ALU_LWSW = 4'b1000;
  localparam logic [3:0] ALU_BEQ  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_issue_ctrl_shift_add_dp.sv
// Shift-add multiply datapath: operand/accumulator registers and the
// per-step partial-product adder. Sequencing lives in mul_issue_ctrl.
module mul_shift_add_dp #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] acc_nxt
);

  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] pp;

  // a * b[STEP-1:0] as a sum of shifted copies of a, mod 2^XLEN.
  always_comb begin
    pp = '0;
    for (int j = 0; j < STEP; j++) begin
      if (b_q[j]) begin
        pp = pp + (a_q << j);
      end
    end
  end

  assign acc_nxt = acc_q + pp;

  // Load clears the accumulator; each step consumes STEP multiplier bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (load) begin
      a_q   <= op_a;
      b_q   <= op_b;
      acc_q <= '0;
    end else if (step) begin
      a_q   <= a_q << STEP;
      b_q   <= b_q >> STEP;
      acc_q <= acc_nxt;
    end
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// EX-stage multiply sequencer: detects MUL, stalls the pipeline and
// drives the iterative shift-add datapath until the low product is ready.
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [3:0]      alu_ctrl_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int N = XLEN / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  mul_state_e      state_q;
  mul_state_e      state_d;
  logic [CW-1:0]   cnt_q;
  logic            start;
  logic            step;
  logic            last;
  logic [XLEN-1:0] acc_nxt;

  assign start = (state_q == ST_IDLE) && valid_i
              && (alu_ctrl_i == ALU_MUL) && !flush_i;
  assign step  = (state_q == ST_BUSY) && !flush_i;
  assign last  = (cnt_q == LAST);

  mul_shift_add_dp #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_dp (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .load    (start),
    .step    (step),
    .op_a    (rs1_data_i),
    .op_b    (rs2_data_i),
    .acc_nxt (acc_nxt)
  );

  // Sequencer state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; a flush in BUSY abandons the multiply.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_BUSY;
      ST_BUSY: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs; stall is low in DONE so the MUL leaves EX that cycle.
  always_comb begin
    busy_o         = (state_q == ST_BUSY);
    result_valid_o = (state_q == ST_DONE);
    stall_o        = rst_i && (start || step);
  end

  // Iteration counter, restarted on every new MUL.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (step) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Result register only moves on BUSY->DONE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      result_o <= '0;
    end else if (step && last) begin
      result_o <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl: vector table plus
// hand-written flush/reset sequences, results tracked in a queue.
module tb_mul_issue_ctrl;
  import mul_issue_ctrl_pkg::*;

  parameter int STEP = 1;
  localparam int XLEN = 32;
  localparam int N = XLEN / STEP;
  localparam int FL = (N > 10) ? 10 : N / 2;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            valid_i;
  logic [3:0]      alu_ctrl_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic            result_valid_o;
  logic [XLEN-1:0] result_o;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [XLEN-1:0] exp_q[$];

  typedef struct {
    logic            vld;
    logic [3:0]      code;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] res;
    bit              scr;
  } vec_t;

  vec_t tbl[16];

  mul_issue_ctrl #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .valid_i        (valid_i),
    .alu_ctrl_i     (alu_ctrl_i),
    .rs1_data_i     (rs1_data_i),
    .rs2_data_i     (rs2_data_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .busy_o         (busy_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string nm,
                       input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] req);
    total_cnt++;
    if (act === req) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%08h want 0x%08h @%0t",
               nm, act, req, $time);
    end
  endtask

  // Every result pulse must match the oldest outstanding MUL.
  always @(negedge clk_i) begin
    if (rst_i === 1'b1 && result_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_pulse: got result 0x%08h want none @%0t",
                 result_o, $time);
      end else begin
        check("result", result_o, exp_q.pop_front());
      end
    end
  end

  task automatic do_mul(input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] res,
                        input bit scr);
    int n;
    @(posedge clk_i); #1;
    valid_i    = 1'b1;
    alu_ctrl_i = ALU_MUL;
    rs1_data_i = a;
    rs2_data_i = b;
    flush_i    = 1'b0;
    exp_q.push_back(res);
    @(negedge clk_i);
    check("start_stall", {31'd0, stall_o}, 1);
    n = 1;
    for (int i = 0; i < N + 4; i++) begin
      @(posedge clk_i); #1;
      if (scr) begin
        rs1_data_i = $urandom;
        rs2_data_i = $urandom;
      end
      @(negedge clk_i);
      if (stall_o !== 1'b1) break;
      n++;
    end
    check("stall_len", n, N + 1);
    check("done_pulse", {31'd0, result_valid_o}, 1);
  endtask

  task automatic do_other(input logic vld, input logic [3:0] code,
                          input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b);
    @(posedge clk_i); #1;
    valid_i    = vld;
    alu_ctrl_i = code;
    rs1_data_i = a;
    rs2_data_i = b;
    flush_i    = 1'b0;
    @(negedge clk_i);
    check("nonmul_stall", {31'd0, stall_o}, 0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("nonmul_busy", {31'd0, busy_o}, 0);
  endtask

  initial begin
    tbl[0]  = '{1, ALU_MUL,  32'd3,        32'd5,        32'h0000000F, 0};
    tbl[1]  = '{1, ALU_ADD,  32'd3,        32'd5,        32'h0,        0};
    tbl[2]  = '{1, ALU_MUL,  32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6, 1};
    tbl[3]  = '{1, ALU_XOR,  32'h1234,     32'h55,       32'h0,        0};
    tbl[4]  = '{1, ALU_MUL,  32'h80000000, 32'd2,        32'h00000000, 0};
    tbl[5]  = '{0, ALU_MUL,  32'd9,        32'd9,        32'h0,        0};
    tbl[6]  = '{1, ALU_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1};
    tbl[7]  = '{1, ALU_SUB,  32'd1,        32'd2,        32'h0,        0};
    tbl[8]  = '{1, ALU_MUL,  32'h00012345, 32'h00000100, 32'h01234500, 0};
    tbl[9]  = '{1, ALU_ADDI, 32'd7,        32'd7,        32'h0,        0};
    tbl[10] = '{1, ALU_MUL,  32'd7,        32'd9,        32'h0000003F, 0};
    tbl[11] = '{1, ALU_MUL,  32'd10,       32'd10,       32'h00000064, 0};
    tbl[12] = '{1, ALU_LWSW, 32'd4,        32'd8,        32'h0,        0};
    tbl[13] = '{1, ALU_BEQ,  32'd4,        32'd4,        32'h0,        0};
    tbl[14] = '{1, ALU_SRAI, 32'd4,        32'd1,        32'h0,        0};
    tbl[15] = '{1, ALU_AND,  32'd4,        32'd1,        32'h0,        0};

    rst_i      = 1'b0;
    valid_i    = 1'b1;
    alu_ctrl_i = ALU_MUL;
    rs1_data_i = 32'd3;
    rs2_data_i = 32'd5;
    flush_i    = 1'b0;
    #3;
    check("rst_stall", {31'd0, stall_o}, 0);
    check("rst_busy", {31'd0, busy_o}, 0);
    check("rst_valid", {31'd0, result_valid_o}, 0);
    check("rst_result", result_o, 0);
    valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].vld && tbl[i].code == ALU_MUL) begin
        do_mul(tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].scr);
      end else begin
        do_other(tbl[i].vld, tbl[i].code, tbl[i].a, tbl[i].b);
      end
    end
    check("result_hold", result_o, 32'h64);

    // Flush partway through BUSY.
    @(posedge clk_i); #1;
    valid_i    = 1'b1;
    alu_ctrl_i = ALU_MUL;
    rs1_data_i = 32'd11;
    rs2_data_i = 32'd13;
    @(negedge clk_i);
    check("fl_start", {31'd0, stall_o}, 1);
    repeat (FL) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    @(negedge clk_i);
    check("fl_stall", {31'd0, stall_o}, 0);
    check("fl_busy", {31'd0, busy_o}, 1);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    @(negedge clk_i);
    check("fl_idle", {31'd0, busy_o}, 0);
    repeat (N + 4) @(negedge clk_i);
    check("fl_result", result_o, 32'h64);

    // Flush while IDLE suppresses start.
    @(posedge clk_i); #1;
    valid_i = 1'b1;
    flush_i = 1'b1;
    @(negedge clk_i);
    check("fli_stall", {31'd0, stall_o}, 0);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    @(negedge clk_i);
    check("fli_busy", {31'd0, busy_o}, 0);

    // Reset mid-operation.
    @(posedge clk_i); #1;
    valid_i    = 1'b1;
    rs1_data_i = 32'd3;
    rs2_data_i = 32'd5;
    repeat (5) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    check("mr_stall", {31'd0, stall_o}, 0);
    check("mr_busy", {31'd0, busy_o}, 0);
    check("mr_valid", {31'd0, result_valid_o}, 0);
    check("mr_result", result_o, 0);
    valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    do_mul(32'd3, 32'd5, 32'h0000000F, 0);

    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check("pending", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
